reset_sequencer: RTL and testbench

Central reset controller for the badminton game. It takes the filtered button reset, soft-restart requests from game logic and PLL lock status. It drives staged, ordered reset release to the design's subsystems: video/VGA first, then game logic, then audio/peripherals. It guarantees a minimum hold time and fixed gaps between releases, and reports ready and busy status plus an event count.

---
 rtl/reset_sequencer.sv | 139 +++++++++++++
 tb/tb_reset_sequencer.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - staged reset release controller with hold, gap timing and event count
module reset_sequencer #(
  parameter int NUM_STAGES  = 3,
  parameter int HOLD_CYCLES = 16,
  parameter int STAGE_GAP   = 8,
  parameter int CNT_W       = 8
) (
  input  logic                  clk,
  input  logic                  rst_in,
  input  logic                  btn_rst,
  input  logic                  soft_rst_req,
  input  logic                  pll_locked,
  output logic [NUM_STAGES-1:0] stage_rst,
  output logic                  busy,
  output logic                  ready,
  output logic [7:0]            rst_count
);

  // Index must be able to hold NUM_STAGES itself: that value marks
  // "all stages released, waiting out the final gap before RUN".
  localparam int IDX_W = $clog2(NUM_STAGES + 1);

  typedef enum logic [1:0] {
    S_WAIT_LOCK = 2'd0,
    S_HOLD      = 2'd1,
    S_RELEASE   = 2'd2,
    S_RUN       = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [NUM_STAGES-1:0] stage_q, stage_d;
  logic                  busy_q, busy_d;
  logic                  ready_q, ready_d;
  logic [7:0]            count_q, count_d;
  logic                  cause;

  assign cause = btn_rst | soft_rst_req;

  // Next-state: PLL loss beats button/soft causes; both abort any release in progress.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    stage_d = stage_q;
    count_d = count_q;

    if (state_q == S_WAIT_LOCK) begin
      stage_d = '1;
      if (pll_locked) begin
        state_d = S_HOLD;
        cnt_d   = '0;
        idx_d   = '0;
      end
    end else if (!pll_locked) begin
      state_d = S_WAIT_LOCK;
      stage_d = '1;
      cnt_d   = '0;
      idx_d   = '0;
    end else if (cause) begin
      state_d = S_HOLD;
      stage_d = '1;
      cnt_d   = '0;
      idx_d   = '0;
      // Only restarts of a running system are counted as reset events.
      if (state_q == S_RUN && count_q != 8'hFF) begin
        count_d = count_q + 8'd1;
      end
    end else begin
      case (state_q)
        S_HOLD: begin
          if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
            state_d    = S_RELEASE;
            stage_d[0] = 1'b0;
            idx_d      = IDX_W'(1);
            cnt_d      = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_RELEASE: begin
          if (cnt_q == CNT_W'(STAGE_GAP - 1)) begin
            cnt_d = '0;
            if (idx_q == IDX_W'(NUM_STAGES)) begin
              state_d = S_RUN;
            end else begin
              for (int i = 0; i < NUM_STAGES; i++) begin
                if (IDX_W'(i) == idx_q) begin
                  stage_d[i] = 1'b0;
                end
              end
              idx_d = idx_q + IDX_W'(1);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_RUN: begin
          stage_d = '0;
        end
        default: begin
          state_d = S_WAIT_LOCK;
          stage_d = '1;
        end
      endcase
    end

    busy_d  = |stage_d;
    ready_d = (state_d == S_RUN);
  end

  // State and output registers; async reset parks everything in reset.
  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      state_q <= S_WAIT_LOCK;
      cnt_q   <= '0;
      idx_q   <= '0;
      stage_q <= '1;
      busy_q  <= 1'b1;
      ready_q <= 1'b0;
      count_q <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      stage_q <= stage_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      count_q <= count_d;
    end
  end

  assign stage_rst = stage_q;
  assign busy      = busy_q;
  assign ready     = ready_q;
  assign rst_count = count_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - directed self-checking bench for reset_sequencer
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst_in;
  logic       btn_rst;
  logic       soft_rst_req;
  logic       pll_locked;
  logic [2:0] stage_rst;
  logic       busy;
  logic       ready;
  logic [7:0] rst_count;

  int checks   = 0;
  int failures = 0;

  reset_sequencer dut (
    .clk          (clk),
    .rst_in       (rst_in),
    .btn_rst      (btn_rst),
    .soft_rst_req (soft_rst_req),
    .pll_locked   (pll_locked),
    .stage_rst    (stage_rst),
    .busy         (busy),
    .ready        (ready),
    .rst_count    (rst_count)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [2:0] es, input logic eb,
                         input logic er, input logic [7:0] ec);
    chk({tag, ".stage"}, 32'(stage_rst), 32'(es));
    chk({tag, ".busy"},  32'(busy),      32'(eb));
    chk({tag, ".ready"}, 32'(ready),     32'(er));
    chk({tag, ".count"}, 32'(rst_count), 32'(ec));
  endtask

  // Called at cycle T (first HOLD cycle with no cause); walks to RUN at T+40.
  task automatic release_seq(input string tag, input logic [7:0] ec);
    ticks(15);
    chk_out({tag, ".t15"}, 3'b111, 1'b1, 1'b0, ec);
    tick();
    chk_out({tag, ".t16"}, 3'b110, 1'b1, 1'b0, ec);
    ticks(7);
    chk({tag, ".t23"}, 32'(stage_rst), 32'(3'b110));
    tick();
    chk({tag, ".t24"}, 32'(stage_rst), 32'(3'b100));
    ticks(7);
    chk({tag, ".t31"}, 32'(stage_rst), 32'(3'b100));
    tick();
    chk_out({tag, ".t32"}, 3'b000, 1'b0, 1'b0, ec);
    ticks(7);
    chk({tag, ".t39"}, 32'(ready), 32'(1'b0));
    tick();
    chk_out({tag, ".t40"}, 3'b000, 1'b0, 1'b1, ec);
  endtask

  initial begin
    rst_in       = 1'b1;
    btn_rst      = 1'b0;
    soft_rst_req = 1'b0;
    pll_locked   = 1'b0;
    #1;
    chk_out("reset", 3'b111, 1'b1, 1'b0, 8'd0);
    ticks(2);
    rst_in = 1'b0;

    // Waiting for lock: stays fully in reset.
    ticks(4);
    chk_out("wait_lock", 3'b111, 1'b1, 1'b0, 8'd0);
    pll_locked = 1'b1;
    tick();
    release_seq("power_up", 8'd0);

    // Soft restart from RUN.
    soft_rst_req = 1'b1;
    tick();
    soft_rst_req = 1'b0;
    chk_out("soft.c1", 3'b111, 1'b1, 1'b0, 8'd1);
    release_seq("soft", 8'd1);

    // Button held 50 cycles.
    btn_rst = 1'b1;
    tick();
    chk_out("btn.c1", 3'b111, 1'b1, 1'b0, 8'd2);
    ticks(49);
    chk_out("btn.c50", 3'b111, 1'b1, 1'b0, 8'd2);
    btn_rst = 1'b0;
    release_seq("btn", 8'd2);

    // Soft request mid-RELEASE while stage_rst=100.
    soft_rst_req = 1'b1;
    tick();
    soft_rst_req = 1'b0;
    chk("rel.enter", 32'(rst_count), 32'd3);
    ticks(24);
    chk("rel.at100", 32'(stage_rst), 32'(3'b100));
    soft_rst_req = 1'b1;
    tick();
    soft_rst_req = 1'b0;
    chk_out("rel.abort", 3'b111, 1'b1, 1'b0, 8'd3);
    release_seq("rel", 8'd3);

    // PLL drop for 3 cycles in RUN.
    pll_locked = 1'b0;
    tick();
    chk_out("pll.c1", 3'b111, 1'b1, 1'b0, 8'd3);
    ticks(2);
    chk_out("pll.c3", 3'b111, 1'b1, 1'b0, 8'd3);
    pll_locked = 1'b1;
    tick();
    release_seq("pll", 8'd3);

    // 260 soft restarts: count saturates at 255.
    for (int n = 0; n < 260; n++) begin
      soft_rst_req = 1'b1;
      tick();
      soft_rst_req = 1'b0;
      ticks(40);
      if (n == 250) chk("sat.254", 32'(rst_count), 32'd254);
      if (n == 251) chk("sat.255", 32'(rst_count), 32'd255);
    end
    chk_out("sat.final", 3'b000, 1'b0, 1'b1, 8'd255);

    // Asynchronous reset mid-RELEASE, checked between clock edges.
    soft_rst_req = 1'b1;
    tick();
    soft_rst_req = 1'b0;
    ticks(20);
    chk("async.pre", 32'(stage_rst), 32'(3'b110));
    #2;
    rst_in = 1'b1;
    #1;
    chk_out("async", 3'b111, 1'b1, 1'b0, 8'd0);
    ticks(2);
    rst_in = 1'b0;
    tick();
    chk_out("async.after", 3'b111, 1'b1, 1'b0, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
